circuito_sequencia_param: RTL and testbench

Parametrised successor of the experiment-3 sequence checker: the player reproduces a stored sequence of switch patterns one play at a time, and the block reports hit or miss.
- Generalised in switch width and sequence depth.
- Plays are edge-detected, so the player no longer needs cycle-timed switch changes.
- An optional inactivity timeout ends the round.
- Sits between the board switches/button and the result LEDs; debug outputs feed the display drivers.

---
 rtl/circuito_sequencia_param.sv | 158 +++++++++++++++
 tb/tb_circuito_sequencia_param.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/circuito_sequencia_param.sv
// Sequence checker: edge-detected plays are compared against an internal ROM; reports hit/miss.
// Latency: jogada in cycle t -> result state at t+3; optional idle timeout via CIRCUITO_SEQUENCIA_TIMEOUT_EN.
// Backpressure: none; plays arriving outside espera are dropped, results hold until iniciar or reset.
module circuito_sequencia_param #(
  parameter int N              = 4,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 5000,
  localparam int A             = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic [N-1:0] chaves,
  output logic         pronto,
  output logic         acertou,
  output logic         errou,
  output logic         db_igual,
  output logic         db_iniciar,
  output logic         db_jogada,
  output logic         db_timeout,
  output logic [A-1:0] db_contagem,
  output logic [N-1:0] db_memoria,
  output logic [N-1:0] db_chaves,
  output logic [3:0]   db_estado
);

  typedef enum logic [3:0] {
    s_inicial     = 4'h0,
    s_preparacao  = 4'h1,
    s_espera      = 4'h2,
    s_registra    = 4'h4,
    s_compara     = 4'h5,
    s_proximo     = 4'h6,
    s_fim_acertou = 4'hA,
    s_fim_errou   = 4'hE
  } estado_t;

  localparam logic [N-1:0] ROM_ONE = N'(1);

  estado_t        estado, prox_estado;
  logic [A-1:0]   endereco;
  logic [N-1:0]   jogada_reg;
  logic [N-1:0]   rom_dat;
  logic           prev_ativo;
  logic           jogada;
  logic           igual;
  logic           ultimo;
  logic           timeout_hit;

  // ROM word i is a one-hot walking pattern: 1 << (i mod N)
  assign rom_dat = ROM_ONE << (int'(endereco) % N);
  assign igual   = (jogada_reg == rom_dat);
  assign ultimo  = (endereco == A'(DEPTH - 1));
  assign jogada  = (|chaves) & ~prev_ativo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_ativo <= 1'b0;
    end else begin
      prev_ativo <= |chaves;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco   <= '0;
      jogada_reg <= '0;
    end else begin
      case (estado)
        s_preparacao: begin
          endereco   <= '0;
          jogada_reg <= '0;
        end
        s_registra: jogada_reg <= chaves;
        s_proximo:  endereco   <= endereco + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CIRCUITO_SEQUENCIA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] ocioso_cnt;

  assign timeout_hit = (estado == s_espera) && !jogada &&
                       (ocioso_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ocioso_cnt <= '0;
      db_timeout <= 1'b0;
    end else begin
      ocioso_cnt <= (estado == s_espera) ? ocioso_cnt + 1'b1 : '0;
      if (estado == s_preparacao) begin
        db_timeout <= 1'b0;
      end else if (timeout_hit) begin
        db_timeout <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign db_timeout         = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= s_inicial;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    pronto      = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    case (estado)
      s_inicial:    if (iniciar) prox_estado = s_preparacao;
      s_preparacao: prox_estado = s_espera;
      // a play arriving on the last idle cycle takes priority over the timeout
      s_espera: begin
        if (jogada)           prox_estado = s_registra;
        else if (timeout_hit) prox_estado = s_fim_errou;
      end
      s_registra:   prox_estado = s_compara;
      s_compara: begin
        if (!igual)      prox_estado = s_fim_errou;
        else if (ultimo) prox_estado = s_fim_acertou;
        else             prox_estado = s_proximo;
      end
      s_proximo:    prox_estado = s_espera;
      s_fim_acertou: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        if (iniciar) prox_estado = s_preparacao;
      end
      s_fim_errou: begin
        pronto = 1'b1;
        errou  = 1'b1;
        if (iniciar) prox_estado = s_preparacao;
      end
      default:      prox_estado = s_inicial;
    endcase
  end

  assign db_igual    = igual;
  assign db_iniciar  = iniciar;
  assign db_jogada   = jogada;
  assign db_contagem = endereco;
  assign db_memoria  = rom_dat;
  assign db_chaves   = jogada_reg;
  assign db_estado   = estado;

endmodule

// File: tb/tb_circuito_sequencia_param.sv
// Directed bench for circuito_sequencia_param with N=4, DEPTH=4, TIMEOUT_CYCLES=8.
// Vector k drives inputs for one cycle; expectations are the outputs just after that cycle's edge.
module tb_circuito_sequencia_param;

  localparam logic [3:0] INI = 4'h0, PRE = 4'h1, ESP = 4'h2, REG = 4'h4,
                         CMP = 4'h5, PRX = 4'h6, FAC = 4'hA, FER = 4'hE;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] chaves;
  logic       pronto, acertou, errou, db_igual, db_iniciar, db_jogada, db_timeout;
  logic [1:0] db_contagem;
  logic [3:0] db_memoria, db_chaves, db_estado;

  int n_vec = 0;
  int n_bad = 0;

  circuito_sequencia_param #(.N(4), .DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .pronto(pronto), .acertou(acertou), .errou(errou), .db_igual(db_igual),
    .db_iniciar(db_iniciar), .db_jogada(db_jogada), .db_timeout(db_timeout),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_chaves(db_chaves),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      nm;
    logic       ini;
    logic [3:0] ch;
    logic [3:0] est;
    logic [1:0] cont;
    logic [2:0] pae;   // {pronto, acertou, errou}
    logic [3:0] dch;
    logic       ig;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string nm, logic ini, logic [3:0] ch, logic [3:0] est,
                              logic [1:0] cont, logic [2:0] pae, logic [3:0] dch, logic ig);
    vec_t v;
    v.nm = nm; v.ini = ini; v.ch = ch; v.est = est;
    v.cont = cont; v.pae = pae; v.dch = dch; v.ig = ig;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input logic ini, input logic [3:0] est,
                       input logic [1:0] cont, input logic [2:0] pae, input logic [3:0] dch,
                       input logic ig, input logic to);
    logic [3:0] mem;
    mem = 4'b0001 << cont;
    n_vec++;
    if (db_estado !== est || db_contagem !== cont || {pronto, acertou, errou} !== pae ||
        db_chaves !== dch || db_igual !== ig || db_timeout !== to ||
        db_memoria !== mem || db_iniciar !== ini) begin
      n_bad++;
      $display("FAIL %s: got est=%h cont=%0d pae=%b ch=%b ig=%b to=%b mem=%b ini=%b, want est=%h cont=%0d pae=%b ch=%b ig=%b to=%b mem=%b ini=%b",
               nm, db_estado, db_contagem, {pronto, acertou, errou}, db_chaves, db_igual,
               db_timeout, db_memoria, db_iniciar, est, cont, pae, dch, ig, to, mem, ini);
    end
  endtask

  task automatic step(input string nm, input logic ini, input logic [3:0] ch,
                      input logic [3:0] est, input logic [1:0] cont, input logic [2:0] pae,
                      input logic [3:0] dch, input logic ig, input logic to);
    iniciar = ini;
    chaves  = ch;
    @(posedge clock);
    #1;
    check(nm, ini, est, cont, pae, dch, ig, to);
  endtask

  initial begin
    // full successful round
    add("ok_ini",  1, 4'b0000, PRE, 0, 3'b000, 4'b0000, 0);
    add("ok_prep", 0, 4'b0000, ESP, 0, 3'b000, 4'b0000, 0);
    add("ok_p0r",  0, 4'b0001, REG, 0, 3'b000, 4'b0000, 0);
    add("ok_p0c",  0, 4'b0001, CMP, 0, 3'b000, 4'b0001, 1);
    add("ok_p0n",  0, 4'b0001, PRX, 0, 3'b000, 4'b0001, 1);
    add("ok_w1",   0, 4'b0000, ESP, 1, 3'b000, 4'b0001, 0);
    add("ok_p1r",  0, 4'b0010, REG, 1, 3'b000, 4'b0001, 0);
    add("ok_p1c",  0, 4'b0010, CMP, 1, 3'b000, 4'b0010, 1);
    add("ok_p1n",  0, 4'b0010, PRX, 1, 3'b000, 4'b0010, 1);
    add("ok_w2",   0, 4'b0000, ESP, 2, 3'b000, 4'b0010, 0);
    add("ok_p2r",  0, 4'b0100, REG, 2, 3'b000, 4'b0010, 0);
    add("ok_p2c",  0, 4'b0100, CMP, 2, 3'b000, 4'b0100, 1);
    add("ok_p2n",  0, 4'b0100, PRX, 2, 3'b000, 4'b0100, 1);
    add("ok_w3",   0, 4'b0000, ESP, 3, 3'b000, 4'b0100, 0);
    add("ok_p3r",  0, 4'b1000, REG, 3, 3'b000, 4'b0100, 0);
    add("ok_p3c",  0, 4'b1000, CMP, 3, 3'b000, 4'b1000, 1);
    add("ok_done", 0, 4'b1000, FAC, 3, 3'b110, 4'b1000, 1);
    for (int i = 0; i < 10; i++) add("ok_hold", 0, 4'b0000, FAC, 3, 3'b110, 4'b1000, 1);
    // wrong second play
    add("er_ini",  1, 4'b0000, PRE, 3, 3'b000, 4'b1000, 1);
    add("er_prep", 0, 4'b0000, ESP, 0, 3'b000, 4'b0000, 0);
    add("er_p0r",  0, 4'b0001, REG, 0, 3'b000, 4'b0000, 0);
    add("er_p0c",  0, 4'b0001, CMP, 0, 3'b000, 4'b0001, 1);
    add("er_p0n",  0, 4'b0001, PRX, 0, 3'b000, 4'b0001, 1);
    add("er_w1",   0, 4'b0000, ESP, 1, 3'b000, 4'b0001, 0);
    add("er_p1r",  0, 4'b0100, REG, 1, 3'b000, 4'b0001, 0);
    add("er_p1c",  0, 4'b0100, CMP, 1, 3'b000, 4'b0100, 0);
    add("er_done", 0, 4'b0100, FER, 1, 3'b101, 4'b0100, 0);
    add("er_hold", 0, 4'b0000, FER, 1, 3'b101, 4'b0100, 0);
    add("er_hold", 0, 4'b0000, FER, 1, 3'b101, 4'b0100, 0);
    // nonzero-to-nonzero changes give a single play; iniciar ignored in espera
    add("gl_ini",  1, 4'b0000, PRE, 1, 3'b000, 4'b0100, 0);
    add("gl_prep", 0, 4'b0000, ESP, 0, 3'b000, 4'b0000, 0);
    add("gl_p0r",  1, 4'b0001, REG, 0, 3'b000, 4'b0000, 0);
    add("gl_p0c",  0, 4'b0001, CMP, 0, 3'b000, 4'b0001, 1);
    add("gl_p0n",  0, 4'b0001, PRX, 0, 3'b000, 4'b0001, 1);
    add("gl_11a",  0, 4'b0011, ESP, 1, 3'b000, 4'b0001, 0);
    add("gl_11b",  0, 4'b0011, ESP, 1, 3'b000, 4'b0001, 0);
    add("gl_11c",  0, 4'b0011, ESP, 1, 3'b000, 4'b0001, 0);
    add("gl_01a",  0, 4'b0001, ESP, 1, 3'b000, 4'b0001, 0);
    add("gl_01b",  0, 4'b0001, ESP, 1, 3'b000, 4'b0001, 0);
    add("gl_zero", 0, 4'b0000, ESP, 1, 3'b000, 4'b0001, 0);

    reset   = 1'b1;
    iniciar = 1'b0;
    chaves  = 4'b0101;
    repeat (2) @(posedge clock);
    #1;
    check("reset", 0, INI, 0, 3'b000, 4'b0000, 0, 0);
    chaves = 4'b0000;
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("idle", 0, INI, 0, 3'b000, 4'b0000, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].nm, tbl[i].ini, tbl[i].ch, tbl[i].est, tbl[i].cont,
           tbl[i].pae, tbl[i].dch, tbl[i].ig, 1'b0);
    end

    // reset asserted while in compara takes effect without a clock edge
    step("rs_p1r", 0, 4'b0010, REG, 1, 3'b000, 4'b0001, 0, 0);
    step("rs_p1c", 0, 4'b0010, CMP, 1, 3'b000, 4'b0010, 1, 0);
    #2;
    reset  = 1'b1;
    chaves = 4'b0000;
    #1;
    check("rs_async", 0, INI, 0, 3'b000, 4'b0000, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    step("rs_ini",  1, 4'b0000, PRE, 0, 3'b000, 4'b0000, 0, 0);
    step("rs_prep", 0, 4'b0000, ESP, 0, 3'b000, 4'b0000, 0, 0);
    step("rs_p0r",  0, 4'b0001, REG, 0, 3'b000, 4'b0000, 0, 0);
    step("rs_p0c",  0, 4'b0001, CMP, 0, 3'b000, 4'b0001, 1, 0);
    step("rs_p0n",  0, 4'b0001, PRX, 0, 3'b000, 4'b0001, 1, 0);
    step("rs_w1",   0, 4'b0000, ESP, 1, 3'b000, 4'b0001, 0, 0);

`ifdef CIRCUITO_SEQUENCIA_TIMEOUT_EN
    // espera entered on the previous edge: eighth idle edge lands in fim_errou
    for (int k = 0; k < 8; k++) begin
      step("to_idle", 0, 4'b0000, (k < 7) ? ESP : FER, 1,
           (k < 7) ? 3'b000 : 3'b101, 4'b0001, 0, (k == 7));
    end
    step("to_ini",  1, 4'b0000, PRE, 1, 3'b000, 4'b0001, 0, 1);
    step("to_prep", 0, 4'b0000, ESP, 0, 3'b000, 4'b0000, 0, 0);
    for (int k = 0; k < 7; k++) step("to_wait", 0, 4'b0000, ESP, 0, 3'b000, 4'b0000, 0, 0);
    step("to_lastr", 0, 4'b0001, REG, 0, 3'b000, 4'b0000, 0, 0);
    step("to_lastc", 0, 4'b0001, CMP, 0, 3'b000, 4'b0001, 1, 0);
    step("to_lastn", 0, 4'b0001, PRX, 0, 3'b000, 4'b0001, 1, 0);
    step("to_w1",    0, 4'b0000, ESP, 1, 3'b000, 4'b0001, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
